// File: rtl/clkdiv_frac_ctrl_if.sv
// Configuration request channel for the fractional clock-enable divider
// controller: a valid/ready handshake carrying the enable state and the
// integer/fractional divisor pair.
interface clkdiv_frac_ctrl_if #(
  parameter int W_DIV_INT  = 16,
  parameter int W_DIV_FRAC = 8
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic                  cfg_en;
  logic [W_DIV_INT-1:0]  cfg_div_int;
  logic [W_DIV_FRAC-1:0] cfg_div_frac;

  // Requester side (register block / CPU-facing control)
  modport master (
    output cfg_valid,
    output cfg_en,
    output cfg_div_int,
    output cfg_div_frac,
    input  cfg_ready
  );

  // Controller side
  modport slave (
    input  cfg_valid,
    input  cfg_en,
    input  cfg_div_int,
    input  cfg_div_frac,
    output cfg_ready
  );
endinterface

// File: rtl/clkdiv_frac_ctrl.sv
// Sequencing controller for the integer+fractional clock-enable divider.
// Divisor changes and shutdowns are deferred to a divider output tick so the
// enable stream never carries a truncated or mixed period. A watchdog forces
// the pending action if the divider stops ticking, and flags it in err.
module clkdiv_frac_ctrl #(
  parameter int W_DIV_INT  = 16,
  parameter int W_DIV_FRAC = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  clkdiv_frac_ctrl_if.slave     cfg,
  input  logic                  div_clk_en,
  output logic                  div_en,
  output logic [W_DIV_INT-1:0]  div_int,
  output logic [W_DIV_FRAC-1:0] div_frac,
  output logic                  busy,
  output logic                  err,
  input  logic                  err_clr
);

  // Watchdog spans the longest legal period (2^W_DIV_INT) plus margin.
  localparam int WD_W = W_DIV_INT + 2;
  // Value held on the last tolerated tickless WAIT cycle; the increment
  // from here would reach 2^W_DIV_INT+2, so the action is forced instead.
  localparam logic [WD_W-1:0] WD_LAST =
    {2'b01, {W_DIV_INT{1'b0}}} + {{(WD_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_OFF       = 2'd0,
    S_RUN       = 2'd1,
    S_WAIT_TICK = 2'd2,
    S_WAIT_OFF  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_div_en;
  logic [W_DIV_INT-1:0]  r_div_int;
  logic [W_DIV_FRAC-1:0] r_div_frac;
  logic                  r_cfg_ready;
  logic                  r_busy;
  logic                  r_err;

  logic [W_DIV_INT-1:0]  r_pend_int;
  logic [W_DIV_FRAC-1:0] r_pend_frac;
  logic [WD_W-1:0]       r_wd_cnt;

  logic                  w_div_en_nxt;
  logic [W_DIV_INT-1:0]  w_div_int_nxt;
  logic [W_DIV_FRAC-1:0] w_div_frac_nxt;
  logic                  w_err_nxt;
  logic                  w_xfer;
  logic                  w_reject;
  logic                  w_wd_exp;
  logic                  w_fire;
  logic                  w_pend_ld;
  logic                  w_wd_clr;
  logic                  w_set_err;
  logic                  w_in_wait;

  // Enabling with a zero integer divisor would stall the divider.
  function automatic logic f_is_reject(input logic en,
                                       input logic [W_DIV_INT-1:0] dint);
    return en && (dint == '0);
  endfunction

  // Next-value for the sticky error flag; a set event beats a clear.
  function automatic logic f_err_next(input logic cur, input logic set,
                                      input logic clr);
    if (set)      return 1'b1;
    else if (clr) return 1'b0;
    else          return cur;
  endfunction

  assign w_xfer    = cfg.cfg_valid && r_cfg_ready;
  assign w_reject  = w_xfer && f_is_reject(cfg.cfg_en, cfg.cfg_div_int);
  assign w_in_wait = (r_state == S_WAIT_TICK) || (r_state == S_WAIT_OFF);
  // Entry to WAIT is always the cycle after the transfer, so any tick seen
  // while waiting is strictly later than the transfer cycle.
  assign w_wd_exp  = (r_wd_cnt == WD_LAST) && !div_clk_en;
  assign w_fire    = div_clk_en || w_wd_exp;

  // Next-state and next-output decode for the controller FSM
  always_comb begin
    w_state_nxt    = r_state;
    w_div_en_nxt   = r_div_en;
    w_div_int_nxt  = r_div_int;
    w_div_frac_nxt = r_div_frac;
    w_pend_ld      = 1'b0;
    w_wd_clr       = 1'b0;
    w_set_err      = 1'b0;
    unique case (r_state)
      S_OFF: begin
        if (w_reject) begin
          w_set_err = 1'b1;
        end else if (w_xfer) begin
          w_div_int_nxt  = cfg.cfg_div_int;
          w_div_frac_nxt = cfg.cfg_div_frac;
          if (cfg.cfg_en) begin
            w_div_en_nxt = 1'b1;
            w_state_nxt  = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (w_reject) begin
          w_set_err = 1'b1;
        end else if (w_xfer) begin
          w_wd_clr = 1'b1;
          if (cfg.cfg_en) begin
            w_pend_ld   = 1'b1;
            w_state_nxt = S_WAIT_TICK;
          end else begin
            w_state_nxt = S_WAIT_OFF;
          end
        end
      end
      S_WAIT_TICK: begin
        if (w_fire) begin
          w_div_int_nxt  = r_pend_int;
          w_div_frac_nxt = r_pend_frac;
          w_state_nxt    = S_RUN;
          w_set_err      = w_wd_exp;
        end
      end
      S_WAIT_OFF: begin
        if (w_fire) begin
          w_div_en_nxt = 1'b0;
          w_state_nxt  = S_OFF;
          w_set_err    = w_wd_exp;
        end
      end
      default: begin
        w_state_nxt = S_OFF;
      end
    endcase
    w_err_nxt = f_err_next(r_err, w_set_err, err_clr);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_OFF;
    else        r_state <= w_state_nxt;
  end

  // Registered divider drive and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_en    <= 1'b0;
      r_div_int   <= {{(W_DIV_INT-1){1'b0}}, 1'b1};
      r_div_frac  <= '0;
      r_cfg_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_div_en    <= w_div_en_nxt;
      r_div_int   <= w_div_int_nxt;
      r_div_frac  <= w_div_frac_nxt;
      r_cfg_ready <= (w_state_nxt == S_OFF) || (w_state_nxt == S_RUN);
      r_busy      <= (w_state_nxt == S_WAIT_TICK) || (w_state_nxt == S_WAIT_OFF);
      r_err       <= w_err_nxt;
    end
  end

  // Pending divisor captured on a running change request
  always_ff @(posedge clk) begin
    if (w_pend_ld) begin
      r_pend_int  <= cfg.cfg_div_int;
      r_pend_frac <= cfg.cfg_div_frac;
    end
  end

  // Watchdog: counts tickless WAIT cycles, restarted on every WAIT entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_wd_cnt <= '0;
    else if (w_wd_clr)                r_wd_cnt <= '0;
    else if (w_in_wait && !div_clk_en) r_wd_cnt <= r_wd_cnt + 1'b1;
  end

  assign cfg.cfg_ready = r_cfg_ready;
  assign div_en        = r_div_en;
  assign div_int       = r_div_int;
  assign div_frac      = r_div_frac;
  assign busy          = r_busy;
  assign err           = r_err;

endmodule

// File: tb/tb_clkdiv_frac_ctrl.sv
// Directed bench for clkdiv_frac_ctrl: a per-cycle vector table for the main
// sequencing behaviour, then hand sequences for watchdog and mid-wait reset.
module tb_clkdiv_frac_ctrl;
  localparam int WI = 4;
  localparam int WF = 8;

  logic          clk;
  logic          rst_n;
  logic          div_clk_en;
  logic          err_clr;
  logic          div_en;
  logic [WI-1:0] div_int;
  logic [WF-1:0] div_frac;
  logic          busy;
  logic          err;

  int n_checks;
  int n_errors;

  clkdiv_frac_ctrl_if #(.W_DIV_INT(WI), .W_DIV_FRAC(WF)) u_if ();

  clkdiv_frac_ctrl #(.W_DIV_INT(WI), .W_DIV_FRAC(WF)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg        (u_if.slave),
    .div_clk_en (div_clk_en),
    .div_en     (div_en),
    .div_int    (div_int),
    .div_frac   (div_frac),
    .busy       (busy),
    .err        (err),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic          en;
    logic [WI-1:0] di;
    logic [WF-1:0] df;
    logic          tk;
    logic          clr;
    logic          x_en;
    logic [WI-1:0] x_di;
    logic [WF-1:0] x_df;
    logic          x_rdy;
    logic          x_busy;
    logic          x_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic en, input logic [WI-1:0] di,
                       input logic [WF-1:0] df, input logic tk, input logic clr);
    u_if.cfg_valid    = v;
    u_if.cfg_en       = en;
    u_if.cfg_div_int  = di;
    u_if.cfg_div_frac = df;
    div_clk_en        = tk;
    err_clr           = clr;
  endtask

  task automatic chk_all(input string tag, input logic x_en, input logic [WI-1:0] x_di,
                         input logic [WF-1:0] x_df, input logic x_rdy,
                         input logic x_busy, input logic x_err);
    chk({tag, ".div_en"},   32'(div_en),         32'(x_en));
    chk({tag, ".div_int"},  32'(div_int),        32'(x_di));
    chk({tag, ".div_frac"}, 32'(div_frac),       32'(x_df));
    chk({tag, ".ready"},    32'(u_if.cfg_ready), 32'(x_rdy));
    chk({tag, ".busy"},     32'(busy),           32'(x_busy));
    chk({tag, ".err"},      32'(err),            32'(x_err));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;

    //            v  en di  df     tk clr | en di  df     rdy bsy err
    vecs.push_back('{0, 0, 0, 8'h00, 0, 0,  0, 1, 8'h00, 1, 0, 0}); // idle OFF
    vecs.push_back('{1, 1, 4, 8'h00, 0, 0,  1, 4, 8'h00, 1, 0, 0}); // enable from OFF
    vecs.push_back('{0, 0, 0, 8'h00, 1, 0,  1, 4, 8'h00, 1, 0, 0}); // tick ignored in RUN
    vecs.push_back('{1, 1, 7, 8'h80, 0, 0,  1, 4, 8'h00, 0, 1, 0}); // change request
    vecs.push_back('{0, 0, 0, 8'h00, 0, 0,  1, 4, 8'h00, 0, 1, 0}); // still waiting
    vecs.push_back('{0, 0, 0, 8'h00, 1, 0,  1, 7, 8'h80, 1, 0, 0}); // tick applies
    vecs.push_back('{1, 1, 9, 8'h11, 1, 0,  1, 7, 8'h80, 0, 1, 0}); // coincident tick
    vecs.push_back('{0, 0, 0, 8'h00, 0, 0,  1, 7, 8'h80, 0, 1, 0}); // not applied
    vecs.push_back('{0, 0, 0, 8'h00, 1, 0,  1, 9, 8'h11, 1, 0, 0}); // next tick applies
    vecs.push_back('{1, 1, 0, 8'h33, 0, 0,  1, 9, 8'h11, 1, 0, 1}); // reject in RUN
    vecs.push_back('{0, 0, 0, 8'h00, 0, 1,  1, 9, 8'h11, 1, 0, 0}); // err clear
    vecs.push_back('{1, 0, 5, 8'h44, 0, 0,  1, 9, 8'h11, 0, 1, 0}); // shutdown request
    vecs.push_back('{0, 0, 0, 8'h00, 0, 0,  1, 9, 8'h11, 0, 1, 0}); // waiting for tick
    vecs.push_back('{0, 0, 0, 8'h00, 1, 0,  0, 9, 8'h11, 1, 0, 0}); // off after tick
    vecs.push_back('{1, 0, 0, 8'h22, 0, 0,  0, 0, 8'h22, 1, 0, 0}); // OFF load, int=0 ok
    vecs.push_back('{1, 1, 0, 8'h55, 0, 0,  0, 0, 8'h22, 1, 0, 1}); // reject in OFF
    vecs.push_back('{1, 1, 0, 8'h66, 0, 1,  0, 0, 8'h22, 1, 0, 1}); // set beats clear
    vecs.push_back('{0, 0, 0, 8'h00, 0, 1,  0, 0, 8'h22, 1, 0, 0}); // err clear
    vecs.push_back('{1, 1, 3, 8'h01, 0, 0,  1, 3, 8'h01, 1, 0, 0}); // enable again

    step();
    step();
    rst_n = 1'b1;
    chk_all("reset", 1'b0, WI'(1), WF'(0), 1'b1, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].en, vecs[i].di, vecs[i].df, vecs[i].tk, vecs[i].clr);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].x_en, vecs[i].x_di, vecs[i].x_df,
              vecs[i].x_rdy, vecs[i].x_busy, vecs[i].x_err);
    end

    // Watchdog: no tick after a change request; forced apply on the 18th wait cycle
    drive(1'b1, 1'b1, 4'd6, 8'h02, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("wd.enter_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 17; k++) begin
      step();
      chk($sformatf("wd.hold%0d.busy", k), 32'(busy), 32'd1);
      chk($sformatf("wd.hold%0d.int", k), 32'(div_int), 32'd3);
    end
    step();
    chk_all("wd.fire", 1'b1, 4'd6, 8'h02, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    step();
    chk("wd.clr", 32'(err), 32'd0);

    // Reset while in WAIT_OFF: outputs return to reset values without a clock edge
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("rst.waitoff_busy", 32'(busy), 32'd1);
    step();
    chk("rst.waitoff_en", 32'(div_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all("rst.async", 1'b0, WI'(1), WF'(0), 1'b1, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    step();
    chk_all("rst.after", 1'b0, WI'(1), WF'(0), 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    step();
    chk_all("rst.tick_off", 1'b0, WI'(1), WF'(0), 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 4'd2, 8'h09, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    chk_all("rst.reenable", 1'b1, 4'd2, 8'h09, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/clkdiv_frac_ctrl.md
# clkdiv_frac_ctrl

Sequencing controller for the integer+fractional clock-enable divider. It accepts divisor and enable requests over a valid/ready interface and drives the divider's `en`, `div_int` and `div_frac` inputs. Divisor changes and shutdowns take effect only on a divider output tick, so the generated enable stream never contains a truncated or mixed period. It sits between a register block or CPU-facing control and one divider instance, whose `clk_en` output it observes.

## Interface
Parameters:
- `W_DIV_INT`, 16, integer divisor width; must match the divider.
- `W_DIV_FRAC`, 8, fractional divisor width; must match the divider.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `cfg_valid`  in  1  request valid.
- `cfg_ready`  out  1  controller can accept a request.
- `cfg_en`  in  1  requested divider enable state.
- `cfg_div_int`  in  `W_DIV_INT`  requested integer divisor.
- `cfg_div_frac`  in  `W_DIV_FRAC`  requested fractional divisor.
- `div_clk_en`  in  1  tick from the divider's `clk_en` output.
- `div_en`  out  1  to divider `en`.
- `div_int`  out  `W_DIV_INT`  to divider `div_int`.
- `div_frac`  out  `W_DIV_FRAC`  to divider `div_frac`.
- `busy`  out  1  a change is pending on a tick.
- `err`  out  1  sticky error flag.
- `err_clr`  in  1  clears `err`.

## Operation
- All outputs are registered.
- Reset values:
  - `div_en`=0, `div_int`=1, `div_frac`=0.
  - `cfg_ready`=1, `busy`=0, `err`=0.
  - State OFF, watchdog counter 0.
- Handshake:
  - A request transfers on any cycle with `cfg_valid && cfg_ready`.
  - `cfg_ready` = 1 in OFF and RUN, 0 in WAIT_TICK and WAIT_OFF.
  - The request payload is sampled only on the transfer cycle.
- Validation:
  - A transfer with `cfg_en`=1 and `cfg_div_int`=0 is rejected.
  - A rejected request still completes its handshake, sets `err`, and leaves the state and all divider outputs unchanged.
- States:
  - OFF, `cfg_en`=1: load `div_int`/`div_frac`, set `div_en`=1, go to RUN.
  - OFF, `cfg_en`=0: load `div_int`/`div_frac` (`cfg_div_int`=0 is allowed here), stay in OFF, `div_en` stays 0.
  - RUN, `cfg_en`=1: latch the payload into the pending registers, go to WAIT_TICK.
  - RUN, `cfg_en`=0: go to WAIT_OFF (payload ignored).
  - WAIT_TICK, on a qualifying tick: copy pending to `div_int`/`div_frac` together, go to RUN.
  - WAIT_OFF, on a qualifying tick: `div_en`=0, go to OFF. The divisor outputs are left unchanged.
- Qualifying tick: `div_clk_en`=1 on a cycle strictly after the transfer cycle. A tick coincident with the transfer is ignored.
- `busy` = 1 exactly while in WAIT_TICK or WAIT_OFF.
- Watchdog:
  - Counter width `W_DIV_INT`+2. It clears on entry to either WAIT state and increments each WAIT cycle without a tick.
  - When it reaches 2^`W_DIV_INT`+2 with no tick, the pending action completes as if a tick had occurred, and `err` is set.
  - This limit exceeds the longest legal divider period, 2^`W_DIV_INT` cycles.
- `err`:
  - Set by a rejected request or a watchdog expiry.
  - Cleared by `err_clr`.
  - If a set event and `err_clr` occur in the same cycle, set wins.
- `div_clk_en` is ignored in OFF and RUN.

## Timing
- OFF enable: transfer at cycle N; `div_en`, `div_int` and `div_frac` update at N+1; the divider's first tick appears at N+2.
- Divisor change: tick at cycle T (T > transfer cycle).
  - New `div_int`/`div_frac` are visible at T+1.
  - The state is RUN at T+1, so `cfg_ready`=1 at T+1.
  - The period already in flight at T completes with the old divisor; the next reload uses the new one.
- Shutdown: tick at T; `div_en`=0 at T+1. The tick at T is the last tick the divider emits.
- OFF-state loads and rejections: one-cycle effect; `cfg_ready` never drops.
- Back-to-back requests: a new request can transfer on the first cycle back in RUN or OFF.
- Reset mid-operation (`rst_n` low in any state):
  - All outputs return to reset values immediately (asynchronously).
  - The pending request is discarded.

## Test plan
- Enable from OFF: reset, then transfer `cfg_en`=1, int=4, frac=0 at cycle 10 -> `div_en`=1 and `div_int`=4 at cycle 11; `busy` stays 0.
- Change while running: running at int=4; transfer int=7, frac=0x80 while `div_clk_en` is low -> `busy`=1 and `cfg_ready`=0. At the next tick T, `div_int`=7 and `div_frac`=0x80 appear together at T+1, and `busy`=0.
- Coincident tick: transfer on the same cycle as `div_clk_en`=1 -> no update at the next cycle; the update lands one cycle after the following tick.
- Shutdown: running; transfer `cfg_en`=0 -> `div_en` stays 1 until a tick at T, then `div_en`=0 at T+1 and the state is OFF; no tick follows.
- Errors:
  - Running; transfer `cfg_en`=1, int=0 -> `err`=1, outputs unchanged, `cfg_ready`=1.
  - In WAIT_TICK with `div_clk_en` held low (`W_DIV_INT`=4) -> forced apply after 18 cycles and `err`=1.
  - `err_clr` asserted together with a new set event -> `err` stays 1.
- Reset mid-wait: `rst_n` low while in WAIT_OFF -> `div_en`=0, `div_int`=1, `busy`=0 immediately; after release, the controller is in OFF with `cfg_ready`=1.
